// File: rtl/reg_file_sb.sv
// reg_file_sb: parametrised register file with write-first read bypass,
// optional hardwired-zero register 0, and a per-register busy scoreboard
// used by ID to detect RAW hazards against in-flight producers.
//
// Ports:
//   CLOCK          rising-edge clock
//   RESET          synchronous active-high reset
//   WRITE          write-back enable
//   INADDRESS      write-back address
//   IN             write-back data
//   ISSUE          mark ISSUE_ADDRESS as pending
//   ISSUE_ADDRESS  destination of the issuing instruction
//   OUTADDRESS     packed read addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   OUT            registered read data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   OUT_BUSY       registered busy flag per read port
//   BUSY_COUNT     registered number of busy registers
module reg_file_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2,
  parameter int ZERO_REG   = 1
) (
  input  logic                           CLOCK,
  input  logic                           RESET,
  input  logic                           WRITE,
  input  logic [ADDR_WIDTH-1:0]          INADDRESS,
  input  logic [DATA_WIDTH-1:0]          IN,
  input  logic                           ISSUE,
  input  logic [ADDR_WIDTH-1:0]          ISSUE_ADDRESS,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] OUTADDRESS,
  output logic [NUM_READ*DATA_WIDTH-1:0] OUT,
  output logic [NUM_READ-1:0]            OUT_BUSY,
  output logic [ADDR_WIDTH:0]            BUSY_COUNT
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam bit ZR    = (ZERO_REG != 0);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]      r_busy;

  logic                  w_wr_en;
  logic                  w_iss_en;
  logic [DEPTH-1:0]      w_busy_nxt;
  logic [ADDR_WIDTH:0]   w_busy_cnt;
  logic [NUM_READ*DATA_WIDTH-1:0] w_rd_data;
  logic [NUM_READ-1:0]   w_rd_busy;

  // Register 0 swallows writes and issues when it is hardwired to zero.
  assign w_wr_en  = WRITE && !(ZR && (INADDRESS == '0));
  assign w_iss_en = ISSUE && !(ZR && (ISSUE_ADDRESS == '0));

  // Clear first, then set, so a same-edge issue supersedes the write-back.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_wr_en)  w_busy_nxt[INADDRESS]     = 1'b0;
    if (w_iss_en) w_busy_nxt[ISSUE_ADDRESS] = 1'b1;
  end

  // Population count cannot overflow: at most DEPTH bits, ADDR_WIDTH+1 wide.
  always_comb begin
    w_busy_cnt = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_busy_cnt = w_busy_cnt + (ADDR_WIDTH+1)'(w_busy_nxt[k]);
    end
  end

  always_comb begin
    w_rd_data = '0;
    w_rd_busy = '0;
    for (int p = 0; p < NUM_READ; p++) begin
      logic [ADDR_WIDTH-1:0] w_a;
      w_a = OUTADDRESS[p*ADDR_WIDTH +: ADDR_WIDTH];
      if (ZR && (w_a == '0))
        w_rd_data[p*DATA_WIDTH +: DATA_WIDTH] = '0;
      else if (WRITE && (INADDRESS == w_a))
        w_rd_data[p*DATA_WIDTH +: DATA_WIDTH] = IN;
      else
        w_rd_data[p*DATA_WIDTH +: DATA_WIDTH] = r_mem[w_a];
      w_rd_busy[p] = w_busy_nxt[w_a];
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_busy     <= '0;
      OUT        <= '0;
      OUT_BUSY   <= '0;
      BUSY_COUNT <= '0;
    end else begin
      if (w_wr_en) r_mem[INADDRESS] <= IN;
      r_busy     <= w_busy_nxt;
      OUT        <= w_rd_data;
      OUT_BUSY   <= w_rd_busy;
      BUSY_COUNT <= w_busy_cnt;
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr;
  logic [4:0]  inaddr;
  logic [31:0] indata;
  logic        iss;
  logic [4:0]  issaddr;
  logic [19:0] raddr;

  logic [127:0] out1;
  logic [3:0]   ob1;
  logic [5:0]   bc1;
  logic [63:0]  out0;
  logic [1:0]   ob0;
  logic [5:0]   bc0;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  // Main DUT: four read ports, register 0 hardwired.
  reg_file_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(4), .ZERO_REG(1)) dut1 (
    .CLOCK(clk), .RESET(rst), .WRITE(wr), .INADDRESS(inaddr), .IN(indata),
    .ISSUE(iss), .ISSUE_ADDRESS(issaddr), .OUTADDRESS(raddr),
    .OUT(out1), .OUT_BUSY(ob1), .BUSY_COUNT(bc1)
  );

  // Second DUT: two read ports, register 0 ordinary; shares ports 0/1 addresses.
  reg_file_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2), .ZERO_REG(0)) dut0 (
    .CLOCK(clk), .RESET(rst), .WRITE(wr), .INADDRESS(inaddr), .IN(indata),
    .ISSUE(iss), .ISSUE_ADDRESS(issaddr), .OUTADDRESS(raddr[9:0]),
    .OUT(out0), .OUT_BUSY(ob0), .BUSY_COUNT(bc0)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a0, a1, a2, a3);
    raddr = {a3, a2, a1, a0};
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; wr = 1'b0; inaddr = '0; indata = '0;
    iss = 1'b0; issaddr = '0; raddr = '0;
    tick;
    chk("reset_out", out1, '0);
    chk("reset_busy", ob1, '0);
    chk("reset_count", bc1, '0);

    // write r5, issue r6, then reset with competing write/issue
    rst = 1'b0; wr = 1'b1; inaddr = 5'd5; indata = 32'hDEADBEEF;
    iss = 1'b1; issaddr = 5'd6; rd(5, 5, 6, 6);
    tick;
    chk("pre_reset_count", bc1, 6'd1);
    rst = 1'b1;
    tick;
    chk("rst_out", out1, '0);
    chk("rst_busy", ob1, '0);
    chk("rst_count", bc1, '0);
    rst = 1'b0; wr = 1'b0; iss = 1'b0; rd(5, 5, 6, 6);
    tick;
    chk("r5_after_reset", out1, '0);
    chk("r6_busy_after_reset", ob1, '0);

    // plain write then read on two ports
    wr = 1'b1; inaddr = 5'd7; indata = 32'h12345678;
    tick;
    wr = 1'b0; rd(7, 7, 5, 5);
    tick;
    chk("r7_two_ports", out1[63:0], {32'h12345678, 32'h12345678});
    chk("r7_dut0", out0, {32'h12345678, 32'h12345678});

    // write-first bypass
    wr = 1'b1; inaddr = 5'd3; indata = 32'h1;
    tick;
    indata = 32'hA5A5A5A5; rd(7, 3, 5, 5);
    tick;
    chk("bypass_p1", out1[63:32], 32'hA5A5A5A5);
    chk("bypass_p0", out1[31:0], 32'h12345678);
    wr = 1'b0;
    tick;
    chk("stored_r3", out1[63:32], 32'hA5A5A5A5);

    // register 0 behaviour in both configurations
    wr = 1'b1; inaddr = 5'd0; indata = 32'hFFFFFFFF;
    iss = 1'b1; issaddr = 5'd0; rd(0, 0, 0, 0);
    tick;
    chk("z1_out", out1, '0);
    chk("z1_busy", ob1, '0);
    chk("z1_count", bc1, '0);
    chk("z0_out_bypass", out0, {32'hFFFFFFFF, 32'hFFFFFFFF});
    chk("z0_busy", ob0, 2'b11);
    chk("z0_count", bc0, 6'd1);
    wr = 1'b0; iss = 1'b0;
    tick;
    chk("z1_out_hold", out1, '0);
    chk("z0_out_stored", out0[31:0], 32'hFFFFFFFF);
    chk("z0_busy_hold", ob0, 2'b11);

    // issue r9, read busy, then write-back clears it
    iss = 1'b1; issaddr = 5'd9; rd(9, 9, 9, 9);
    tick;
    chk("r9_busy_issue", ob1, 4'b1111);
    chk("r9_count_issue", bc1, 6'd1);
    iss = 1'b0;
    tick;
    chk("r9_busy_hold", ob1, 4'b1111);
    wr = 1'b1; inaddr = 5'd9; indata = 32'h55;
    tick;
    chk("r9_wb_data", out1[31:0], 32'h55);
    chk("r9_wb_busy", ob1, 4'b0000);
    chk("r9_wb_count", bc1, 6'd0);
    chk("r9_wb_count_dut0", bc0, 6'd1);
    wr = 1'b0;

    // same-edge issue and write on a busy register: set wins
    iss = 1'b1; issaddr = 5'd4; rd(4, 4, 4, 4);
    tick;
    chk("r4_count_issue", bc1, 6'd1);
    wr = 1'b1; inaddr = 5'd4; indata = 32'h77;
    tick;
    chk("r4_data4", out1, {4{32'h77}});
    chk("r4_busy4", ob1, 4'b1111);
    chk("r4_count", bc1, 6'd1);
    wr = 1'b0; iss = 1'b0;
    tick;
    chk("r4_stored", out1, {4{32'h77}});

    // mixed ports with a second busy register
    iss = 1'b1; issaddr = 5'd10; rd(4, 10, 0, 9);
    tick;
    chk("mix_data", out1, {32'h55, 32'h0, 32'h0, 32'h77});
    chk("mix_busy", ob1, 4'b0011);
    chk("mix_count", bc1, 6'd2);

    // mid-stream reset ignores write and issue
    rst = 1'b1; wr = 1'b1; inaddr = 5'd11; indata = 32'hCAFEF00D;
    iss = 1'b1; issaddr = 5'd12; rd(11, 12, 4, 9);
    tick;
    chk("mid_rst_out", out1, '0);
    chk("mid_rst_count", bc1, '0);
    chk("mid_rst_count_dut0", bc0, '0);
    rst = 1'b0; wr = 1'b0; iss = 1'b0;
    tick;
    chk("post_rst_out", out1, '0);
    chk("post_rst_busy", ob1, '0);
    chk("post_rst_count", bc1, '0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
